odd_sequence_checker: RTL and testbench
=======================================

ODD_SEQUENCE_CHECKER -- requirements
Module: odd_sequence_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 3: consecutive correct samples needed to enter LOCKED (legal range 1-7).
REQ-002 The block SHALL have parameter UNLOCK_COUNT, default 2: consecutive mismatches in LOCKED that force return to IDLE (legal range 1-7).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Clear  input  1  asynchronous, active-low reset; Clear=0 resets immediately regardless of clk.
REQ-005 sample  input  1  single-cycle strobe, one per counter step; no input is evaluated when sample=0.
REQ-006 sel  input  2  counter mode; 2'b11 = odd-count mode, any other value = counter held at zero.
REQ-007 Q_in  input  4  counter value under check.
REQ-008 locked  output  1  high while state is LOCKED.
REQ-009 err  output  1  one-cycle pulse on each counted error.
REQ-010 err_cnt  output  8  saturating count of err pulses.
REQ-011 expected  output  4  value predicted for the next sample.
REQ-012 state  output  2  IDLE=2'b00, SYNC=2'b01, LOCKED=2'b10; 2'b11 unused.

Function
REQ-013 All outputs SHALL be registered; an evaluated sample at edge N SHALL be reflected on outputs after edge N (one-cycle latency).
REQ-014 succ(v) SHALL be: 1 if v=0; 1 if v=15; v+2 otherwise, 4-bit result.
REQ-015 With sample=0 the block SHALL hold all state, and err SHALL be 0.
REQ-016 Sample with sel!=2'b11, any state: state->IDLE, match/mismatch counters->0, expected->0; if Q_in!=0, err pulses and err_cnt increments.
REQ-017 IDLE, sample, sel=2'b11: Q_in odd or 0 -> SYNC, expected=succ(Q_in), good count=1; Q_in even nonzero -> stay IDLE, no err.
REQ-018 SYNC, sample, Q_in=expected: good count+1, expected=succ(expected); when good count reaches LOCK_COUNT -> LOCKED, mismatch count=0.
REQ-019 SYNC, sample, Q_in!=expected: no err; reseed per REQ-017 on the same sample (odd/0 -> stay SYNC, good count=1; even nonzero -> IDLE).
REQ-020 LOCKED, sample, Q_in=expected: expected=succ(expected), mismatch count=0.
REQ-021 LOCKED, sample, Q_in=0 and expected!=0: counter restart, no err, expected=1, mismatch count=0, stay LOCKED.
REQ-022 LOCKED, sample, other mismatch: err pulse, err_cnt+1, mismatch count+1, expected=succ(expected) (flywheel); when mismatch count reaches UNLOCK_COUNT -> IDLE, expected=0.
REQ-023 err_cnt SHALL saturate at 255 and never wrap; err still pulses when saturated.
REQ-024 With LOCK_COUNT=1, a single valid seed in IDLE SHALL go directly to LOCKED.
REQ-025 State 2'b11, if ever reached, SHALL return to IDLE on the next clk edge.

Reset
REQ-026 Clear=0 SHALL asynchronously force state=IDLE, locked=0, err=0, err_cnt=0, expected=0, internal counters=0.
REQ-027 Reset mid-operation SHALL discard all history; first sample after Clear rises follows REQ-017.
REQ-028 Clear SHALL take priority over sample on any coincident edge.

Verification
REQ-029 Reset, sel=11, samples 1,3,5 -> state SYNC,SYNC,LOCKED; locked=1 after third sample; err never 1; expected=7.
REQ-030 Locked at expected=15, sample 15 then 1 -> expected 1 then 3; no err (wrap-around).
REQ-031 Locked, samples 9 (expected 7) then 4 -> two err pulses, err_cnt=2, state IDLE after second, expected=0.
REQ-032 Locked, sample 0 -> no err, expected=1, locked stays 1.
REQ-033 sel=01, sample Q_in=0 -> IDLE, no err; Q_in=5 -> err pulse, err_cnt+1.
REQ-034 Force 260 mismatches -> err_cnt stops at 255; assert Clear=0 between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/odd_sequence_checker.sv
// Tracks an odd-count counter sampled on a strobe; locks after LOCK_COUNT correct
// steps, flags mismatches while locked and drops lock after UNLOCK_COUNT misses.
module odd_sequence_checker #(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic       clk,
  input  logic       Clear,
  input  logic       sample,
  input  logic [1:0] sel,
  input  logic [3:0] Q_in,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [3:0] expected,
  output logic [1:0] state
);

  localparam int unsigned DW  = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned CIW = CW + 1;
  localparam int unsigned EW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_RSVD   = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   good_q, good_d;
  logic [CW-1:0]   mis_q, mis_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic            err_q, err_d;
  logic            locked_q, locked_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [CIW-1:0]  good_inc, mis_inc;
  logic            seed_ok;

  // Next odd count value; 0 and 15 both step to 1.
  function automatic logic [DW-1:0] succ(input logic [DW-1:0] v);
    if (v == '0 || v == '1) return DW'(1);
    return v + DW'(2);
  endfunction

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    mis_d    = mis_q;
    exp_d    = exp_q;
    err_d    = 1'b0;
    ecnt_d   = ecnt_q;
    good_inc = {1'b0, good_q} + CIW'(1);
    mis_inc  = {1'b0, mis_q} + CIW'(1);
    seed_ok  = Q_in[0] | (Q_in == '0);

    if (state_q == ST_RSVD) begin
      state_d = ST_IDLE;
      good_d  = '0;
      mis_d   = '0;
      exp_d   = '0;
    end else if (sample) begin
      if (sel != 2'b11) begin
        state_d = ST_IDLE;
        good_d  = '0;
        mis_d   = '0;
        exp_d   = '0;
        err_d   = (Q_in != '0);
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (seed_ok) begin
              state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_SYNC;
              good_d  = CW'(1);
              mis_d   = '0;
              exp_d   = succ(Q_in);
            end
          end
          ST_SYNC: begin
            if (Q_in == exp_q) begin
              good_d = good_inc[CW-1:0];
              exp_d  = succ(exp_q);
              if (good_inc >= CIW'(LOCK_COUNT)) begin
                state_d = ST_LOCKED;
                mis_d   = '0;
              end
            end else if (seed_ok) begin
              // Mismatch during sync reseeds from the current sample.
              state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_SYNC;
              good_d  = CW'(1);
              mis_d   = '0;
              exp_d   = succ(Q_in);
            end else begin
              state_d = ST_IDLE;
              good_d  = '0;
              mis_d   = '0;
              exp_d   = '0;
            end
          end
          ST_LOCKED: begin
            if (Q_in == exp_q) begin
              exp_d = succ(exp_q);
              mis_d = '0;
            end else if (Q_in == '0) begin
              exp_d = DW'(1);
              mis_d = '0;
            end else begin
              // Flywheel: keep predicting until too many misses in a row.
              err_d = 1'b1;
              mis_d = mis_inc[CW-1:0];
              exp_d = succ(exp_q);
              if (mis_inc >= CIW'(UNLOCK_COUNT)) begin
                state_d = ST_IDLE;
                good_d  = '0;
                mis_d   = '0;
                exp_d   = '0;
              end
            end
          end
          default: ;
        endcase
      end
    end

    if (err_d && (ecnt_q != '1)) ecnt_d = ecnt_q + EW'(1);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state_q  <= ST_IDLE;
      good_q   <= '0;
      mis_q    <= '0;
      exp_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      mis_q    <= mis_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = ecnt_q;
  assign expected = exp_q;
  assign state    = state_q;

endmodule

// File: tb/tb_odd_sequence_checker.sv
// Bench for odd_sequence_checker: two instances (default and single-seed lock)
// driven in parallel and compared against a rule-level model.
module tb_odd_sequence_checker;

  logic       clk;
  logic       Clear;
  logic       sample;
  logic [1:0] sel;
  logic [3:0] q_in;

  logic       locked_a, err_a, locked_b, err_b;
  logic [7:0] err_cnt_a, err_cnt_b;
  logic [3:0] expected_a, expected_b;
  logic [1:0] state_a, state_b;

  int checks;
  int failures;

  typedef struct packed {
    int st;
    int ex;
    int good;
    int mis;
    int ecnt;
    int err;
  } mdl_t;

  mdl_t ma, mb;

  odd_sequence_checker #(.LOCK_COUNT(3), .UNLOCK_COUNT(2)) dut_a (
    .clk(clk), .Clear(Clear), .sample(sample), .sel(sel), .Q_in(q_in),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a),
    .expected(expected_a), .state(state_a)
  );

  odd_sequence_checker #(.LOCK_COUNT(1), .UNLOCK_COUNT(3)) dut_b (
    .clk(clk), .Clear(Clear), .sample(sample), .sel(sel), .Q_in(q_in),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b),
    .expected(expected_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int nxt(input int v);
    if (v == 0 || v == 15) return 1;
    return (v + 2) % 16;
  endfunction

  // One evaluated sample according to the written rules; st: 0 idle, 1 sync, 2 locked.
  function automatic mdl_t step(input mdl_t m, input int s, input int q,
                                input int lc, input int uc);
    mdl_t n;
    n = m;
    n.err = 0;
    if (s != 3) begin
      n.st = 0; n.good = 0; n.mis = 0; n.ex = 0;
      n.err = (q != 0) ? 1 : 0;
    end else if (m.st == 2) begin
      if (q == m.ex) begin
        n.ex = nxt(m.ex); n.mis = 0;
      end else if (q == 0) begin
        n.ex = 1; n.mis = 0;
      end else begin
        n.err = 1; n.mis = m.mis + 1; n.ex = nxt(m.ex);
        if (n.mis >= uc) begin
          n.st = 0; n.ex = 0; n.mis = 0; n.good = 0;
        end
      end
    end else if (m.st == 1 && q == m.ex) begin
      n.good = m.good + 1; n.ex = nxt(m.ex);
      if (n.good >= lc) begin n.st = 2; n.mis = 0; end
    end else if (q % 2 == 1 || q == 0) begin
      n.st = (lc == 1) ? 2 : 1; n.good = 1; n.mis = 0; n.ex = nxt(q);
    end else if (m.st == 1) begin
      n.st = 0; n.good = 0; n.mis = 0; n.ex = 0;
    end
    if (n.err == 1 && n.ecnt < 255) n.ecnt = n.ecnt + 1;
    return n;
  endfunction

  task automatic check_outputs();
    check_eq("a.state",    int'(state_a),    ma.st);
    check_eq("a.locked",   int'(locked_a),   (ma.st == 2) ? 1 : 0);
    check_eq("a.err",      int'(err_a),      ma.err);
    check_eq("a.err_cnt",  int'(err_cnt_a),  ma.ecnt);
    check_eq("a.expected", int'(expected_a), ma.ex);
    check_eq("b.state",    int'(state_b),    mb.st);
    check_eq("b.locked",   int'(locked_b),   (mb.st == 2) ? 1 : 0);
    check_eq("b.err",      int'(err_b),      mb.err);
    check_eq("b.err_cnt",  int'(err_cnt_b),  mb.ecnt);
    check_eq("b.expected", int'(expected_b), mb.ex);
  endtask

  task automatic do_sample(input logic [1:0] s, input logic [3:0] q);
    @(negedge clk);
    sample = 1'b1; sel = s; q_in = q;
    @(posedge clk);
    #1;
    sample = 1'b0;
    ma = step(ma, int'(s), int'(q), 3, 2);
    mb = step(mb, int'(s), int'(q), 1, 3);
    check_outputs();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sel = 2'($urandom_range(0, 3));
    q_in = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    ma.err = 0; mb.err = 0;
    check_outputs();
  endtask

  // Clear dropped between edges must zero everything without a clock.
  task automatic async_clear();
    @(posedge clk);
    #3;
    Clear = 1'b0;
    #1;
    ma = '0; mb = '0;
    check_outputs();
    @(negedge clk);
    Clear = 1'b1;
  endtask

  initial begin
    logic [1:0] s;
    logic [3:0] q;
    int r;
    checks = 0; failures = 0;
    Clear = 1'b0; sample = 1'b0; sel = 2'b00; q_in = 4'd0;
    ma = '0; mb = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    Clear = 1'b1;

    // Seed and lock on 1,3,5.
    do_sample(2'b11, 4'd1);
    check_eq("seq1.state", int'(state_a), 1);
    do_sample(2'b11, 4'd3);
    do_sample(2'b11, 4'd5);
    check_eq("seq5.locked", int'(locked_a), 1);
    check_eq("seq5.expected", int'(expected_a), 7);
    check_eq("seq5.err_cnt", int'(err_cnt_a), 0);
    idle_cycle();

    // Two misses while locked drop instance a to idle.
    do_sample(2'b11, 4'd9);
    check_eq("miss1.err", int'(err_a), 1);
    do_sample(2'b11, 4'd4);
    check_eq("miss2.err_cnt", int'(err_cnt_a), 2);
    check_eq("miss2.state", int'(state_a), 0);
    check_eq("miss2.expected", int'(expected_a), 0);

    // Wrap from 15 to 1.
    async_clear();
    do_sample(2'b11, 4'd9);
    do_sample(2'b11, 4'd11);
    do_sample(2'b11, 4'd13);
    check_eq("wrap.pre", int'(expected_a), 15);
    do_sample(2'b11, 4'd15);
    check_eq("wrap.15", int'(expected_a), 1);
    do_sample(2'b11, 4'd1);
    check_eq("wrap.1", int'(expected_a), 3);
    check_eq("wrap.err_cnt", int'(err_cnt_a), 0);

    // Counter restart while locked.
    do_sample(2'b11, 4'd0);
    check_eq("restart.expected", int'(expected_a), 1);
    check_eq("restart.locked", int'(locked_a), 1);

    // Held mode.
    do_sample(2'b01, 4'd0);
    check_eq("held0.err", int'(err_a), 0);
    do_sample(2'b01, 4'd5);
    check_eq("held5.err_cnt", int'(err_cnt_a), 1);

    // Clear held low across a sampling edge wins.
    @(negedge clk);
    sample = 1'b1; sel = 2'b01; q_in = 4'd7; Clear = 1'b0;
    @(posedge clk);
    #1;
    ma = '0; mb = '0;
    check_outputs();
    @(negedge clk);
    sample = 1'b0; Clear = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      s = (r < 8) ? 2'($urandom_range(0, 2)) : 2'b11;
      r = int'($urandom_range(0, 99));
      if (r < 60) q = 4'(ma.ex);
      else if (r < 70) q = 4'(mb.ex);
      else if (r < 78) q = 4'd0;
      else q = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) idle_cycle();
      if ($urandom_range(0, 299) == 0) async_clear();
      do_sample(s, q);
    end

    // Saturation of the error counter.
    async_clear();
    for (int i = 0; i < 260; i++) do_sample(2'b01, 4'd5);
    check_eq("sat.err_cnt", int'(err_cnt_a), 255);
    check_eq("sat.err", int'(err_a), 1);
    async_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
